// File: rtl/im_dm_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Holds the access-owner encoding, default widths and the simulation end marker.
package im_dm_arb_pkg;

  localparam int ADDR_W_DEF     = 14;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    DM_RD = 2'd2
  } owner_t;

  localparam logic [13:0] SIM_END_ADDR = 14'h3FFF;
  localparam logic [31:0] SIM_END_CODE = 32'hFFFFFFFF;

endpackage

// File: rtl/im_dm_starve_ctr.sv
// Saturating loss counter for the fetch port; at_max forces fetch to win.
// Clear takes priority over increment.
module im_dm_starve_ctr
  import im_dm_arb_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(MAX))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_max = (r_cnt == CW'(MAX));

endmodule

// File: rtl/im_dm_arbiter.sv
// Shares one single-port byte-writable SRAM between instruction fetch and data memory.
// Optional macro IM_DM_SIM_END_DETECT_EN adds a sticky sim_done output.
module im_dm_arbiter
  import im_dm_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic [DATA_W/8-1:0] dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_cs,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_di,
`ifdef IM_DM_SIM_END_DETECT_EN
  input  logic [DATA_W-1:0]   mem_do,
  output logic                sim_done
`else
  input  logic [DATA_W-1:0]   mem_do
`endif
);

  localparam int BE_W = DATA_W / 8;

  owner_t            r_state;
  owner_t            w_state_next;
  logic              w_at_max;
  logic              w_if_win;
  logic              w_dm_win;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  // Fetch wins alone or once it has lost STARVE_MAX times in a row.
  assign w_if_win = if_req && (!dm_req || w_at_max);
  assign w_dm_win = dm_req && !w_if_win;

  // Grants are suppressed while reset is held so the SRAM sees no access.
  assign if_gnt   = w_if_win && rst;
  assign dm_gnt   = w_dm_win && rst;
  assign mem_cs   = if_gnt || dm_gnt;
  assign mem_we   = dm_gnt ? dm_we : '0;
  assign mem_addr = w_dm_win ? dm_addr : if_addr;
  assign mem_di   = dm_wdata;

  im_dm_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (if_req && !if_gnt),
    .i_clr    (if_gnt || !if_req),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = IDLE;
    if_rvalid    = 1'b0;
    dm_rvalid    = 1'b0;
    if_rdata     = r_if_rdata;
    dm_rdata     = r_dm_rdata;
    if (if_gnt) begin
      w_state_next = IF_RD;
    end else if (dm_gnt && (dm_we == '0)) begin
      w_state_next = DM_RD;
    end
    if (r_state == IF_RD) begin
      if_rvalid = 1'b1;
      if_rdata  = mem_do;
    end
    if (r_state == DM_RD) begin
      dm_rvalid = 1'b1;
      dm_rdata  = mem_do;
    end
  end

  // Capture returned words so rdata holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (r_state == IF_RD) r_if_rdata <= mem_do;
      if (r_state == DM_RD) r_dm_rdata <= mem_do;
    end
  end

`ifdef IM_DM_SIM_END_DETECT_EN
  logic r_sim_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sim_done <= 1'b0;
    end else if (dm_gnt && (dm_we == {BE_W{1'b1}}) &&
                 (dm_addr == ADDR_W'(SIM_END_ADDR)) &&
                 (dm_wdata == DATA_W'(SIM_END_CODE))) begin
      r_sim_done <= 1'b1;
    end
  end

  assign sim_done = r_sim_done;
`endif

endmodule

// File: tb/tb_im_dm_arbiter.sv
// Directed scoreboard bench for im_dm_arbiter with a behavioural single-port SRAM.
// Read expectations are queued at grant time and popped by a monitor on rvalid.
module tb_im_dm_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [13:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [13:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_cs;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_do;
`ifdef IM_DM_SIM_END_DETECT_EN
  logic        sim_done;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] mem [0:16383];
  logic [31:0] mon_exp;

  im_dm_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_di    (mem_di),
`ifdef IM_DM_SIM_END_DETECT_EN
    .mem_do    (mem_do),
    .sim_done  (sim_done)
`else
    .mem_do    (mem_do)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM: lane writes on the access edge, read data one cycle later.
  always @(posedge clk) begin
    if (mem_cs) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_di[b*8 +: 8];
      if (mem_we == 4'h0) mem_do <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (if_rvalid) begin
        if (if_q.size() == 0) chk("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
        else begin
          mon_exp = if_q.pop_front();
          chk("if_rdata", if_rdata, mon_exp);
        end
      end
      if (dm_rvalid) begin
        if (dm_q.size() == 0) chk("dm_rvalid_unexpected", 32'(dm_rvalid), 32'd0);
        else begin
          mon_exp = dm_q.pop_front();
          chk("dm_rdata", dm_rdata, mon_exp);
        end
      end
      if (if_rvalid || dm_rvalid)
        chk("rvalid_overlap", 32'(if_rvalid && dm_rvalid), 32'd0);
    end
  end

  task automatic step(input string nm, input logic e_if, input logic e_dm, input logic [3:0] e_we);
    @(negedge clk);
    chk({nm, "_if_gnt"}, 32'(if_gnt), 32'(e_if));
    chk({nm, "_dm_gnt"}, 32'(dm_gnt), 32'(e_dm));
    chk({nm, "_mem_we"}, 32'(mem_we), 32'(e_we));
    @(posedge clk); #1;
  endtask

  task automatic contend(input string nm);
    logic exp_if [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    if_req = 1'b1; if_addr = 14'h0100;
    dm_req = 1'b1; dm_we = 4'h0; dm_addr = 14'h0200;
    for (int i = 0; i < 6; i++) begin
      if (exp_if[i]) if_q.push_back(32'hCAFEF00D);
      else           dm_q.push_back(32'h0BADBEEF);
      step($sformatf("%s_c%0d", nm, i), exp_if[i], !exp_if[i], 4'h0);
    end
    if_req = 1'b0; dm_req = 1'b0;
    step({nm, "_drain"}, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[14'h0010] = 32'h00000093;
    mem[14'h2000] = 32'h11223344;
    mem[14'h0100] = 32'hCAFEF00D;
    mem[14'h0200] = 32'h0BADBEEF;
    mem[14'h3FFF] = 32'h5A5A5A5A;
    mem_do = 32'h0;
    rst = 1'b0;
    if_req = 1'b1; if_addr = 14'h0010;
    dm_req = 1'b1; dm_we = 4'h0; dm_addr = 14'h0200; dm_wdata = 32'h0;

    // Reset state with both requests asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_rvalids", 32'({if_rvalid, dm_rvalid}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
`ifdef IM_DM_SIM_END_DETECT_EN
    chk("rst_sim_done", 32'(sim_done), 32'd0);
`endif
    if_req = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: IF-only fetch, then rdata holds.
    if_req = 1'b1; if_addr = 14'h0010;
    if_q.push_back(32'h00000093);
    step("t1_fetch", 1'b1, 1'b0, 4'h0);
    if_req = 1'b0;
    step("t1_ret", 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    chk("t1_if_rvalid_low", 32'(if_rvalid), 32'd0);
    chk("t1_if_rdata_hold", if_rdata, 32'h00000093);
    @(posedge clk); #1;

    // 2: contention and starvation guard.
    contend("t2");

    // 3: partial byte store then load.
    dm_req = 1'b1; dm_we = 4'b0011; dm_addr = 14'h2000; dm_wdata = 32'hAABBCCDD;
    step("t3_wr", 1'b0, 1'b1, 4'b0011);
    dm_we = 4'h0;
    dm_q.push_back(32'h1122CCDD);
    step("t3_rd", 1'b0, 1'b1, 4'h0);
    dm_req = 1'b0;
    step("t3_ret", 1'b0, 1'b0, 4'h0);

    // 4: back-to-back IF read then DM read.
    if_req = 1'b1; if_addr = 14'h0010;
    if_q.push_back(32'h00000093);
    step("t4_if", 1'b1, 1'b0, 4'h0);
    if_req = 1'b0;
    dm_req = 1'b1; dm_we = 4'h0; dm_addr = 14'h0100;
    dm_q.push_back(32'hCAFEF00D);
    @(negedge clk);
    chk("t4_dm_gnt", 32'(dm_gnt), 32'd1);
    chk("t4_if_rvalid_with_gnt", 32'(if_rvalid), 32'd1);
    @(posedge clk); #1;
    dm_req = 1'b0;
    @(negedge clk);
    chk("t4_dm_rvalid", 32'(dm_rvalid), 32'd1);
    @(posedge clk); #1;

    // 5: reset asserted while a DM read is in flight.
    dm_req = 1'b1; dm_we = 4'h0; dm_addr = 14'h0200;
    @(negedge clk);
    chk("t5_dm_gnt", 32'(dm_gnt), 32'd1);
    rst = 1'b0;
    #1;
    chk("t5_gnt_in_rst", 32'({if_gnt, dm_gnt, mem_cs}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_dm_rvalid_in_rst", 32'(dm_rvalid), 32'd0);
    dm_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    step("t5_post1", 1'b0, 1'b0, 4'h0);
    step("t5_post2", 1'b0, 1'b0, 4'h0);
    contend("t5");

`ifdef IM_DM_SIM_END_DETECT_EN
    // 6: end marker detection; only the full-lane write sets sim_done.
    dm_req = 1'b1; dm_we = 4'h7; dm_addr = 14'h3FFF; dm_wdata = 32'hFFFFFFFF;
    step("t6_wr7", 1'b0, 1'b1, 4'h7);
    dm_req = 1'b0;
    @(negedge clk);
    chk("t6_sim_done_low", 32'(sim_done), 32'd0);
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 4'hF;
    step("t6_wrF", 1'b0, 1'b1, 4'hF);
    dm_req = 1'b0; dm_we = 4'h0;
    @(negedge clk);
    chk("t6_sim_done_set", 32'(sim_done), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_sim_done_sticky", 32'(sim_done), 32'd1);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("dm_q_drained", 32'(dm_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
